// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES types, round-count constants and GF(2^8) helpers
// Revision: 1.0
// ============================================================================
package aes_pkg;

    typedef logic [0:127] aes_state_t;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    localparam logic [7:0] c_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Used with constant coefficients only, so it folds to a small XOR network.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_core_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher_core_if
// Brief   : Block handshake, key-store request and result bus of the core
// Revision: 1.0
// ============================================================================
interface aes_inv_cipher_core_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t ciphertext;
    logic [3:0] rk_idx;
    aes_state_t round_key;
    logic       out_valid;
    logic       out_ready;
    aes_state_t plaintext;
    logic       busy;

    modport master (
        output in_valid, ciphertext, round_key, out_ready,
        input  in_ready, rk_idx, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, round_key, out_ready,
        output in_ready, rk_idx, out_valid, plaintext, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_mix_column.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_mix_column
// Brief   : InvMixColumns on one 32-bit column, byte row 0 in bits [31:24]
// Revision: 1.0
// ============================================================================
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign o_col[31:24] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
    assign o_col[23:16] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
    assign o_col[15:8]  = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
    assign o_col[7:0]   = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher_core
// Brief   : Iterative AES inverse cipher, one round per clock, external keys
// Revision: 1.0
// ============================================================================
module aes_inv_cipher_core
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_cipher_core_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ROUND = 2'd1;
    localparam logic [1:0] c_ST_FINAL = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [3:0] c_NR_IDX = 4'(NR);
    localparam logic [3:0] c_NR_M1  = 4'(NR - 1);

    generate
        if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : g_nr_illegal
            $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_rcnt;
    logic [3:0] w_rk_idx;
    aes_state_t r_st;
    aes_state_t r_pt;
    logic       r_out_valid;
    aes_state_t w_isr;
    aes_state_t w_isb;
    aes_state_t w_ark;
    aes_state_t w_imc;

    // InvShiftRows is pure wiring: out(r,c) takes in(r,(c-r) mod 4).
    for (genvar k = 0; k < 16; k++) begin : g_bytes
        localparam int c_COL = k / 4;
        localparam int c_ROW = k % 4;
        localparam int c_SRC = 4 * ((c_COL - c_ROW + 4) % 4) + c_ROW;
        assign w_isr[8*k +: 8] = r_st[8*c_SRC +: 8];
        assign w_isb[8*k +: 8] = inv_sbox(w_isr[8*k +: 8]);
    end

    assign w_ark = w_isb ^ bus.round_key;

    for (genvar c = 0; c < 4; c++) begin : g_cols
        aes_inv_mix_column u_imc (
            .i_col (w_ark[32*c +: 32]),
            .o_col (w_imc[32*c +: 32])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rk_idx    = 4'd0;
        case (r_state)
            c_ST_IDLE: begin
                w_rk_idx = c_NR_IDX;
                if (bus.in_valid) w_state_nxt = c_ST_ROUND;
            end
            c_ST_ROUND: begin
                w_rk_idx = r_rcnt;
                if (r_rcnt == 4'd1) w_state_nxt = c_ST_FINAL;
            end
            c_ST_FINAL: w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (bus.out_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt      <= 4'd0;
            r_st        <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_st   <= bus.ciphertext ^ bus.round_key;
                        r_rcnt <= c_NR_M1;
                    end
                end
                c_ST_ROUND: begin
                    r_st <= w_imc;
                    if (r_rcnt != 4'd1) r_rcnt <= r_rcnt - 4'd1;
                end
                c_ST_FINAL: begin
                    r_pt        <= w_ark;
                    r_out_valid <= 1'b1;
                end
                c_ST_DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_ST_IDLE);
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.rk_idx    = w_rk_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.plaintext = r_pt;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_inv_cipher_core
// Brief   : Self-checking bench; reference is a forward AES model built from GF math
// Revision: 1.0
// ============================================================================
module tb_aes_inv_cipher_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0]   sbox  [256];
    logic [0:127] rks10 [16];
    logic [0:127] rks14 [16];

    aes_inv_cipher_core_if bus10 ();
    aes_inv_cipher_core_if bus14 ();

    aes_inv_cipher_core #(.NR(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
    aes_inv_cipher_core #(.NR(14)) dut14 (.clk(clk), .rst(rst), .bus(bus14));

    // The bench plays the key-schedule store: same-cycle lookup by rk_idx.
    assign bus10.round_key = rks10[bus10.rk_idx];
    assign bus14.round_key = rks14[bus14.rk_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_entry(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [0:127] round_key_of(input logic [0:255] key, input int nk, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:255] key, input int nr, input logic [0:127] pt);
        logic [0:127] s;
        logic [0:127] t;
        logic [7:0]   a [4];
        s = pt ^ round_key_of(key, nr - 6, 0);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[8*(4*c+r) +: 8] = sbox[s[8*(4*((c + r) % 4) + r) +: 8]];
            s = t;
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
                    for (int r = 0; r < 4; r++)
                        t[8*(4*c+r) +: 8] = gm(a[r], 8'h02) ^ gm(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
                s = t;
            end
            s = s ^ round_key_of(key, nr - 6, rd);
        end
        return s;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_keys10(input logic [0:255] key);
        for (int r = 0; r <= 10; r++) rks10[r] = round_key_of(key, 4, r);
    endtask

    task automatic load_keys14(input logic [0:255] key);
        for (int r = 0; r <= 14; r++) rks14[r] = round_key_of(key, 8, r);
    endtask

    task automatic check(input string tag, input string what, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // One NR=10 block: latency, key-index sequence, result, optional backpressure.
    task automatic run_block10(input string tag, input logic [0:127] ct, input logic [0:127] exp_pt, input int hold);
        logic [63:0] seq_obs;
        logic [63:0] seq_exp;
        int          j;
        check(tag, "in_ready_idle", 128'(bus10.in_ready), 128'(1'b1));
        seq_obs = {60'h0, bus10.rk_idx};
        seq_exp = {60'h0, 4'd10};
        bus10.ciphertext = ct;
        bus10.in_valid   = 1'b1;
        bus10.out_ready  = 1'b0;
        @(negedge clk);
        bus10.in_valid   = 1'b0;
        bus10.ciphertext = rand128();
        j = 0;
        while (!bus10.out_valid && j < 20) begin
            seq_obs = {seq_obs[59:0], bus10.rk_idx};
            seq_exp = {seq_exp[59:0], 4'(9 - j)};
            @(negedge clk);
            j++;
        end
        check(tag, "latency", 128'(j), 128'(10));
        check(tag, "plaintext", bus10.plaintext, exp_pt);
        check(tag, "rk_idx_seq", 128'(seq_obs), 128'(seq_exp));
        for (int k = 0; k < hold; k++) begin
            bus10.in_valid   = (k % 2 == 0);
            bus10.ciphertext = rand128();
            @(negedge clk);
            check(tag, "hold_out_valid", 128'(bus10.out_valid), 128'(1'b1));
            check(tag, "hold_plaintext", bus10.plaintext, exp_pt);
            check(tag, "hold_in_ready", 128'(bus10.in_ready), 128'(1'b0));
        end
        bus10.in_valid  = 1'b0;
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.out_ready = 1'b0;
        check(tag, "drain_out_valid", 128'(bus10.out_valid), 128'(1'b0));
        check(tag, "drain_in_ready", 128'(bus10.in_ready), 128'(1'b1));
        check(tag, "drain_busy", 128'(bus10.busy), 128'(1'b0));
    endtask

    task automatic run_block14(input string tag, input logic [0:127] ct, input logic [0:127] exp_pt);
        int j;
        bus14.ciphertext = ct;
        bus14.in_valid   = 1'b1;
        @(negedge clk);
        bus14.in_valid   = 1'b0;
        bus14.ciphertext = rand128();
        j = 0;
        while (!bus14.out_valid && j < 30) begin
            @(negedge clk);
            j++;
        end
        check(tag, "latency", 128'(j), 128'(14));
        check(tag, "plaintext", bus14.plaintext, exp_pt);
        bus14.out_ready = 1'b1;
        @(negedge clk);
        bus14.out_ready = 1'b0;
        check(tag, "drain_out_valid", 128'(bus14.out_valid), 128'(1'b0));
    endtask

    localparam logic [0:127] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] c_PT_C  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [0:255] key;
        logic [0:127] pt;
        logic [0:127] pts [3];
        logic [0:127] cts [3];
        logic [0:127] exp_q [$];
        logic [0:127] exp_pt;
        int           nin, nout, cyc, last_done, j;

        checks = 0;
        errors = 0;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_entry(8'(x));
        for (int r = 0; r < 16; r++) begin
            rks10[r] = '0;
            rks14[r] = '0;
        end
        rst = 1'b1;
        bus10.in_valid = 1'b0; bus10.out_ready = 1'b0; bus10.ciphertext = '0;
        bus14.in_valid = 1'b0; bus14.out_ready = 1'b0; bus14.ciphertext = '0;
        load_keys10({c_KEY_B, 128'h0});
        repeat (2) @(negedge clk);

        check("reset", "in_ready", 128'(bus10.in_ready), 128'(1'b1));
        check("reset", "out_valid", 128'(bus10.out_valid), 128'(1'b0));
        check("reset", "busy", 128'(bus10.busy), 128'(1'b0));
        check("reset", "plaintext", bus10.plaintext, 128'h0);
        check("reset", "rk_idx10", 128'(bus10.rk_idx), 128'(4'd10));
        check("reset", "rk_idx14", 128'(bus14.rk_idx), 128'(4'd14));
        rst = 1'b0;
        @(negedge clk);

        run_block10("fips_b", c_CT_B, c_PT_B, 0);

        load_keys10({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        run_block10("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c_PT_C, 0);

        for (int b = 0; b < 3; b++) begin
            key = {rand128(), 128'h0};
            pt  = rand128();
            load_keys10(key);
            run_block10((b == 0) ? "backpressure" : "random10", encrypt(key, 10, pt), pt, (b == 0) ? 5 : 0);
        end

        // Reset in round 4: the block must vanish and the core restart cleanly.
        load_keys10({c_KEY_B, 128'h0});
        bus10.ciphertext = c_CT_B;
        bus10.in_valid   = 1'b1;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst", "out_valid", 128'(bus10.out_valid), 128'(1'b0));
        check("midrst", "in_ready", 128'(bus10.in_ready), 128'(1'b1));
        check("midrst", "plaintext", bus10.plaintext, 128'h0);
        check("midrst", "busy", 128'(bus10.busy), 128'(1'b0));
        j = 0;
        while (!bus10.out_valid && j < 14) begin
            @(negedge clk);
            j++;
        end
        check("midrst", "no_output", 128'(bus10.out_valid), 128'(1'b0));
        run_block10("rst_recover", c_CT_B, c_PT_B, 0);

        // Back-to-back with in_valid held high and a scoreboard queue.
        key = {rand128(), 128'h0};
        load_keys10(key);
        for (int i = 0; i < 3; i++) begin
            pts[i] = rand128();
            cts[i] = encrypt(key, 10, pts[i]);
        end
        nin = 0; nout = 0; cyc = 0; last_done = -100;
        bus10.out_ready  = 1'b1;
        bus10.in_valid   = 1'b1;
        bus10.ciphertext = cts[0];
        while (nout < 3 && cyc < 200) begin
            if (bus10.out_valid) begin
                if (exp_q.size() > 0) exp_pt = exp_q.pop_front();
                else                  exp_pt = '0;
                check("b2b", "plaintext", bus10.plaintext, exp_pt);
                nout++;
                last_done = cyc;
            end
            if (bus10.in_ready && bus10.in_valid) begin
                if (nin > 0) check("b2b", "accept_gap", 128'(cyc - last_done), 128'(1));
                exp_q.push_back(pts[nin]);
                nin++;
            end
            @(negedge clk);
            cyc++;
            if (nin < 3) bus10.ciphertext = cts[nin];
            else         bus10.in_valid   = 1'b0;
        end
        check("b2b", "blocks_out", 128'(nout), 128'(3));
        bus10.in_valid  = 1'b0;
        bus10.out_ready = 1'b0;
        @(negedge clk);

        load_keys14(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        run_block14("fips_c3", 128'h8ea2b7ca516745bfeafc49904b496089, c_PT_C);
        key = {rand128(), rand128()};
        pt  = rand128();
        load_keys14(key);
        run_block14("random14", encrypt(key, 14, pt), pt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
